tmr_fault_detector: RTL and testbench

Synthesizable checker at the receiving end of transient-fault injection on triplicated datapath signals. It compares three redundant copies of a word and drives the bitwise majority vote. Each checked cycle is classified as clean, single-lane fault or multi-lane fault, and each lane is tracked through an OK/SUSPECT/DEGRADED state machine. Fault events go out on a valid/ready report port for the bench scoreboard or an on-chip recovery controller.

---
 rtl/fd_pkg.sv | 32 +++
 rtl/tmr_fault_detector_if.sv | 19 +
 rtl/fd_event_fifo.sv | 55 +++++
 rtl/tmr_fault_detector.sv | 162 ++++++++++++++++
 tb/tb_tmr_fault_detector.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fd_pkg.sv
// Shared types for the TMR fault detector: event kinds, lane FSM states,
// the event record carried through the report queue, and lane indices.
package fd_pkg;

    localparam int FD_SYN_W = 32;

    localparam logic [1:0] LANE_A    = 2'd0;
    localparam logic [1:0] LANE_B    = 2'd1;
    localparam logic [1:0] LANE_C    = 2'd2;
    localparam logic [1:0] LANE_NONE = 2'd3;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_SINGLE  = 2'd1,
        EVT_MULTI   = 2'd2,
        EVT_DEGRADE = 2'd3
    } fd_evt_kind_e;

    typedef enum logic [1:0] {
        LS_OK       = 2'd0,
        LS_SUSPECT  = 2'd1,
        LS_DEGRADED = 2'd2
    } fd_lane_state_e;

    // Syndrome field is sized for the widest supported lane; narrower lanes zero-extend.
    typedef struct packed {
        fd_evt_kind_e          kind;
        logic [1:0]            lane;
        logic [FD_SYN_W-1:0]   syndrome;
    } fd_event_t;

endpackage

// File: rtl/tmr_fault_detector_if.sv
// Fault-event report port. valid/ready: an event transfers on a rising edge where
// evt_valid_o and evt_ready_i are both high; payload is held stable while valid waits on ready.
interface tmr_fault_detector_if #(parameter int WIDTH = 32);
    logic             evt_valid_o;
    logic             evt_ready_i;
    logic [1:0]       evt_kind_o;
    logic [1:0]       evt_lane_o;
    logic [WIDTH-1:0] evt_syndrome_o;

    modport master (
        output evt_valid_o, evt_kind_o, evt_lane_o, evt_syndrome_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o, evt_kind_o, evt_lane_o, evt_syndrome_o,
        output evt_ready_i
    );
endinterface

// File: rtl/fd_event_fifo.sv
// First-word-fall-through event queue. A push into a full queue is accepted when a
// pop happens in the same cycle; otherwise it is dropped and flagged on drop_o.
module fd_event_fifo
    import fd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  fd_event_t push_data_i,
    input  logic      pop_i,
    output fd_event_t data_o,
    output logic      valid_o,
    output logic      full_o,
    output logic      drop_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int MEM_N = 1 << PTR_W;

    fd_event_t        mem_q [MEM_N];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [OCC_W-1:0] occ_q;
    logic             empty, pop_ok, push_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (occ_q == '0);
    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign valid_o = ~empty;
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign drop_o  = push_i & full_o & ~pop_ok;
    assign data_o  = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < MEM_N; i++) mem_q[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= next_ptr(wr_q);
            end
            if (pop_ok) rd_q <= next_ptr(rd_q);
            if (push_ok && !pop_ok)      occ_q <= occ_q + 1'b1;
            else if (pop_ok && !push_ok) occ_q <= occ_q - 1'b1;
        end
    end
endmodule

// File: rtl/tmr_fault_detector.sv
// Majority voter and fault classifier for three redundant lanes, with per-lane health FSMs
// and a valid/ready event report. FD_EVENT_FIFO_EN selects a FIFO_DEPTH queue; otherwise depth 1.
module tmr_fault_detector
    import fd_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     lane_a_i,
    input  logic [WIDTH-1:0]     lane_b_i,
    input  logic [WIDTH-1:0]     lane_c_i,
    input  logic                 check_en_i,
    input  logic                 clear_i,
    output logic [WIDTH-1:0]     voted_o,
    output logic                 fault_o,
    output logic [5:0]           lane_state_o,
    tmr_fault_detector_if.master evt,
    output logic [CNT_W-1:0]     total_faults_o,
    output logic [CNT_W-1:0]     dropped_o
);
`ifdef FD_EVENT_FIFO_EN
    localparam int Q_DEPTH = FIFO_DEPTH;
`else
    // Single output register; FIFO_DEPTH has no effect in this build.
    localparam int Q_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
    localparam int CW = $clog2(FAULT_THRESH + 1);

    fd_lane_state_e   state_q [3], state_d [3];
    logic [CW-1:0]    cnt_q [3], cnt_d [3];
    logic [2:0]       degrade_now;
    logic             fault_q;
    logic [CNT_W-1:0] total_q, dropped_q;

    logic             eq_ab, eq_bc, eq_ac, is_clean, is_multi, checked, evt_push;
    logic [1:0]       odd_idx;
    logic [WIDTH-1:0] odd_val;
    fd_event_t        evt_in, evt_out;
    logic             q_drop, q_full;

    assign voted_o  = (lane_a_i & lane_b_i) | (lane_b_i & lane_c_i) | (lane_a_i & lane_c_i);
    assign eq_ab    = (lane_a_i == lane_b_i);
    assign eq_bc    = (lane_b_i == lane_c_i);
    assign eq_ac    = (lane_a_i == lane_c_i);
    assign is_clean = eq_ab & eq_bc;
    assign is_multi = ~eq_ab & ~eq_bc & ~eq_ac;
    assign checked  = check_en_i & ~clear_i;
    assign evt_push = checked & ~is_clean;

    // With exactly one matching pair, the lane outside that pair is the odd one.
    always_comb begin
        odd_idx = LANE_B;
        odd_val = lane_b_i;
        if (eq_ab) begin
            odd_idx = LANE_C;
            odd_val = lane_c_i;
        end else if (eq_bc) begin
            odd_idx = LANE_A;
            odd_val = lane_a_i;
        end
    end

    always_comb begin
        degrade_now = '0;
        for (int l = 0; l < 3; l++) begin
            state_d[l] = state_q[l];
            cnt_d[l]   = cnt_q[l];
            if (clear_i) begin
                state_d[l] = LS_OK;
                cnt_d[l]   = '0;
            end else if (checked) begin
                case (state_q[l])
                    LS_OK: begin
                        if (!is_clean && !is_multi && odd_idx == 2'(l)) begin
                            state_d[l] = LS_SUSPECT;
                            cnt_d[l]   = CW'(1);
                        end
                    end
                    LS_SUSPECT: begin
                        if (!is_clean && !is_multi && odd_idx == 2'(l)) begin
                            cnt_d[l] = cnt_q[l] + 1'b1;
                            if (cnt_q[l] + 1'b1 == CW'(FAULT_THRESH)) begin
                                state_d[l]     = LS_DEGRADED;
                                degrade_now[l] = 1'b1;
                            end
                        end else begin
                            state_d[l] = LS_OK;
                            cnt_d[l]   = '0;
                        end
                    end
                    LS_DEGRADED: state_d[l] = LS_DEGRADED;
                    default: begin
                        state_d[l] = LS_OK;
                        cnt_d[l]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        evt_in          = '0;
        evt_in.kind     = is_multi ? EVT_MULTI : ((|degrade_now) ? EVT_DEGRADE : EVT_SINGLE);
        evt_in.lane     = is_multi ? LANE_NONE : odd_idx;
        evt_in.syndrome = is_multi
            ? FD_SYN_W'((lane_a_i ^ lane_b_i) | (lane_b_i ^ lane_c_i) | (lane_a_i ^ lane_c_i))
            : FD_SYN_W'(odd_val ^ voted_o);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < 3; l++) begin
                state_q[l] <= LS_OK;
                cnt_q[l]   <= '0;
            end
            fault_q   <= 1'b0;
            total_q   <= '0;
            dropped_q <= '0;
        end else begin
            for (int l = 0; l < 3; l++) begin
                state_q[l] <= state_d[l];
                cnt_q[l]   <= cnt_d[l];
            end
            fault_q <= evt_push;
            if (clear_i) begin
                total_q   <= '0;
                dropped_q <= '0;
            end else begin
                if (evt_push && total_q != '1) total_q <= total_q + 1'b1;
                if (q_drop && dropped_q != '1) dropped_q <= dropped_q + 1'b1;
            end
        end
    end

    fd_event_fifo #(.DEPTH(Q_DEPTH)) u_evt_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (evt_push),
        .push_data_i (evt_in),
        .pop_i       (evt.evt_ready_i),
        .data_o      (evt_out),
        .valid_o     (evt.evt_valid_o),
        .full_o      (q_full),
        .drop_o      (q_drop)
    );

    assign evt.evt_kind_o     = evt_out.kind;
    assign evt.evt_lane_o     = evt_out.lane;
    assign evt.evt_syndrome_o = evt_out.syndrome[WIDTH-1:0];
    assign fault_o            = fault_q;
    assign lane_state_o       = {state_q[2], state_q[1], state_q[0]};
    assign total_faults_o     = total_q;
    assign dropped_o          = dropped_q;

    // The full flag only shapes push acceptance inside the queue.
    logic unused_full;
    assign unused_full = q_full;
endmodule

// File: tb/tb_tmr_fault_detector.sv
// Directed bench for tmr_fault_detector: hand-written lane vectors with expected votes,
// events, lane states, counters and queue behaviour in either queue build.
module tb_tmr_fault_detector;
    import fd_pkg::*;

    localparam int W = 32;
`ifdef FD_EVENT_FIFO_EN
    localparam int EXP_DEPTH = 4;
`else
    localparam int EXP_DEPTH = 1;
`endif
    localparam logic [W-1:0] BASE = 32'h1234_5678;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  lane_a, lane_b, lane_c;
    logic          check_en, clear;
    logic [W-1:0]  voted;
    logic          fault;
    logic [5:0]    lane_state;
    logic [15:0]   total_faults, dropped;

    tmr_fault_detector_if #(.WIDTH(W)) evt_if ();

    tmr_fault_detector #(.WIDTH(W), .FAULT_THRESH(4), .CNT_W(16), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lane_a_i       (lane_a),
        .lane_b_i       (lane_b),
        .lane_c_i       (lane_c),
        .check_en_i     (check_en),
        .clear_i        (clear),
        .voted_o        (voted),
        .fault_o        (fault),
        .lane_state_o   (lane_state),
        .evt            (evt_if),
        .total_faults_o (total_faults),
        .dropped_o      (dropped)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard
    logic [35:0] exp_q[$];
    int          vec_cnt = 0;
    int          miscompares = 0;
    int          exp_total = 0;
    int          exp_drop = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_head();
        check_vec("evt_valid", evt_if.evt_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0)
            check_vec("evt_payload", {evt_if.evt_kind_o, evt_if.evt_lane_o, evt_if.evt_syndrome_o},
                      exp_q[0]);
    endtask

    // driver: apply one cycle; called at a falling edge, returns at the next falling edge
    task automatic step(input logic [W-1:0] a, b, c, input logic en, clr,
                        input logic [W-1:0] exp_vote, input logic has_evt,
                        input logic [1:0] kind, lane, input logic [W-1:0] syn);
        lane_a = a; lane_b = b; lane_c = c; check_en = en; clear = clr;
        #1;
        check_vec("voted", voted, exp_vote);
        check_head();
        if (evt_if.evt_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
        if (has_evt) begin
            if (exp_q.size() == EXP_DEPTH) exp_drop++;
            else exp_q.push_back({kind, lane, syn});
            exp_total++;
        end
        if (clr) begin
            exp_total = 0;
            exp_drop  = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_vec("fault", fault, has_evt);
        check_vec("total_faults", total_faults, exp_total);
        check_vec("dropped", dropped, exp_drop);
    endtask

    task automatic clean_step();
        step(BASE, BASE, BASE, 1'b1, 1'b0, BASE, 1'b0, 2'd0, 2'd0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        exp_total = 0;
        exp_drop  = 0;
        check_vec("rst_fault", fault, 1'b0);
        check_vec("rst_state", lane_state, 6'h00);
        check_vec("rst_valid", evt_if.evt_valid_o, 1'b0);
        check_vec("rst_payload", {evt_if.evt_kind_o, evt_if.evt_lane_o, evt_if.evt_syndrome_o}, 36'h0);
        check_vec("rst_total", total_faults, 16'h0);
        check_vec("rst_dropped", dropped, 16'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        lane_a = '0; lane_b = '0; lane_c = '0;
        check_en = 1'b0; clear = 1'b0;
        evt_if.evt_ready_i = 1'b1;
        @(negedge clk);
        do_reset();

        // clean traffic
        for (int i = 0; i < 10; i++) clean_step();
        check_vec("clean_state", lane_state, 6'h00);
        check_vec("clean_total", total_faults, 16'h0);

        // single fault on b, then recovery
        step(BASE, BASE ^ 32'h1, BASE, 1'b1, 1'b0, BASE, 1'b1, 2'd1, 2'd1, 32'h1);
        check_vec("b_suspect", lane_state, 6'h04);
        clean_step();
        check_vec("b_recover", lane_state, 6'h00);

        // c faulty for four checked cycles -> degrade
        for (int i = 0; i < 4; i++) begin
            step(BASE, BASE, BASE ^ 32'h100, 1'b1, 1'b0, BASE, 1'b1,
                 (i == 3) ? 2'd3 : 2'd1, 2'd2, 32'h100);
            check_vec("c_state", lane_state, (i == 3) ? 6'h20 : 6'h10);
        end
        for (int i = 0; i < 3; i++) clean_step();
        check_vec("c_sticky", lane_state, 6'h20);
        step(BASE, BASE, BASE ^ 32'h3, 1'b1, 1'b0, BASE, 1'b1, 2'd1, 2'd2, 32'h3);
        check_vec("c_still_degraded", lane_state, 6'h20);
        step(BASE, BASE ^ 32'h8, BASE, 1'b1, 1'b1, BASE, 1'b0, 2'd0, 2'd0, '0);
        check_vec("clear_state", lane_state, 6'h00);
        check_vec("clear_total", total_faults, 16'h0);

        // SINGLE on another lane returns a suspect lane to OK
        step(BASE, BASE ^ 32'h4, BASE, 1'b1, 1'b0, BASE, 1'b1, 2'd1, 2'd1, 32'h4);
        step(BASE ^ 32'h2, BASE, BASE, 1'b1, 1'b0, BASE, 1'b1, 2'd1, 2'd0, 32'h2);
        check_vec("a_suspect_b_ok", lane_state, 6'h01);

        // MULTI returns a to OK
        step(32'h0, 32'hF, 32'hF0, 1'b1, 1'b0, 32'h0, 1'b1, 2'd2, 2'd3, 32'hFF);
        check_vec("multi_state", lane_state, 6'h00);

        // unchecked cycle leaves FSMs alone and emits nothing
        step(BASE, BASE ^ 32'h10, BASE, 1'b1, 1'b0, BASE, 1'b1, 2'd1, 2'd1, 32'h10);
        step(BASE, BASE ^ 32'h10, BASE, 1'b0, 1'b0, BASE, 1'b0, 2'd0, 2'd0, '0);
        check_vec("unchecked_state", lane_state, 6'h04);
        clean_step();
        clean_step();
        step(BASE, BASE, BASE, 1'b1, 1'b1, BASE, 1'b0, 2'd0, 2'd0, '0);

        // backpressure: six faults with ready low
        evt_if.evt_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++)
            step(BASE, BASE ^ W'(i), BASE, 1'b1, 1'b0, BASE, 1'b1,
                 (i == 4) ? 2'd3 : 2'd1, 2'd1, W'(i));
        check_vec("bp_dropped", dropped, 16'(6 - EXP_DEPTH));
        check_vec("bp_state", lane_state, 6'h08);

        // full queue: pop and push in the same cycle
        evt_if.evt_ready_i = 1'b1;
        step(BASE, BASE ^ 32'h7, BASE, 1'b1, 1'b0, BASE, 1'b1, 2'd1, 2'd1, 32'h7);
        check_vec("full_pop_push_dropped", dropped, 16'(6 - EXP_DEPTH));
        for (int i = 0; i < EXP_DEPTH + 1; i++) clean_step();
        check_vec("drained", evt_if.evt_valid_o, 1'b0);

        // reset mid-operation flushes queued events
        evt_if.evt_ready_i = 1'b0;
        step(BASE ^ 32'h1, BASE, BASE, 1'b1, 1'b0, BASE, 1'b1, 2'd1, 2'd0, 32'h1);
        step(BASE ^ 32'h1, BASE, BASE, 1'b1, 1'b0, BASE, 1'b1, 2'd1, 2'd0, 32'h1);
        do_reset();
        evt_if.evt_ready_i = 1'b1;
        clean_step();

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end
endmodule
